eq_band_mixer: RTL and testbench

//  Parametrised multi-channel equalizer gain/summing stage. Sits after the EQ filter bank:

---
 rtl/eq_band_mixer.sv | 117 +++++++++++
 tb/tb_eq_band_mixer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/eq_band_mixer.sv
// rtl/eq_band_mixer.sv - multi-channel EQ band gain/sum stage, one time-multiplexed MAC per channel
module eq_band_mixer #(
    parameter int NUM_BANDS = 4,
    parameter int NUM_CH    = 2,
    parameter int DATA_W    = 48,
    parameter int GAIN_W    = 16,
    parameter int OUT_W     = 24
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         bypass,
    input  logic                                         eq_wr,
    input  logic [$clog2(NUM_BANDS)-1:0]                 eq_wr_sel,
    input  logic [7:0]                                   eq_gain_lsb,
    input  logic [GAIN_W-9:0]                            eq_gain_msb,
    input  logic                                         sample_valid,
    input  logic [NUM_CH-1:0][NUM_BANDS-1:0][DATA_W-1:0] data_in,
    output logic [NUM_CH-1:0][OUT_W-1:0]                 data_out,
    output logic                                         out_valid,
    output logic                                         busy,
    output logic                                         overrun
);

    localparam int CNT_W  = $clog2(NUM_BANDS);
    localparam int PROD_W = DATA_W + GAIN_W;
    localparam int ACC_W  = PROD_W + CNT_W;
    localparam logic signed [GAIN_W-1:0] UNITY   = GAIN_W'(1) << (GAIN_W - 2);
    localparam logic signed [ACC_W-1:0]  SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_SAT} state_t;

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          band;
    logic signed [GAIN_W-1:0]  pending [NUM_BANDS];
    logic signed [GAIN_W-1:0]  active  [NUM_BANDS];
    logic signed [DATA_W-1:0]  hold    [NUM_CH][NUM_BANDS];
    logic signed [ACC_W-1:0]   acc     [NUM_CH];
    logic signed [GAIN_W-1:0]  g_cur;
    logic signed [PROD_W-1:0]  prod    [NUM_CH];
    logic signed [ACC_W-1:0]   shifted [NUM_CH];
    logic signed [DATA_W-1:0]  clamped [NUM_CH];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (sample_valid) state_nxt = S_MAC;
            S_MAC:   if (band == CNT_W'(NUM_BANDS - 1)) state_nxt = S_SAT;
            S_SAT:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bypass substitutes unity at the multiplier so the stored gains survive untouched
    always_comb begin
        g_cur = bypass ? UNITY : active[band];
        for (int c = 0; c < NUM_CH; c++) begin
            prod[c]    = PROD_W'(hold[c][band]) * PROD_W'(g_cur);
            shifted[c] = acc[c] >>> (GAIN_W - 2);
            if (shifted[c] > SAT_MAX)
                clamped[c] = SAT_MAX[DATA_W-1:0];
            else if (shifted[c] < SAT_MIN)
                clamped[c] = SAT_MIN[DATA_W-1:0];
            else
                clamped[c] = shifted[c][DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            band      <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            data_out  <= '0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                pending[b] <= UNITY;
                active[b]  <= UNITY;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] <= '0;
                for (int b = 0; b < NUM_BANDS; b++) hold[c][b] <= '0;
            end
        end else begin
            state     <= state_nxt;
            out_valid <= 1'b0;
            if (eq_wr && int'(eq_wr_sel) < NUM_BANDS)
                pending[eq_wr_sel] <= {eq_gain_msb, eq_gain_lsb};
            if (sample_valid && state != S_IDLE)
                overrun <= 1'b1;
            case (state)
                S_IDLE: if (sample_valid) begin
                    // Active gains take the pre-write pending values, so a same-cycle eq_wr lands next sample
                    for (int b = 0; b < NUM_BANDS; b++) active[b] <= pending[b];
                    for (int c = 0; c < NUM_CH; c++) begin
                        acc[c] <= '0;
                        for (int b = 0; b < NUM_BANDS; b++) hold[c][b] <= data_in[c][b];
                    end
                    band <= '0;
                    busy <= 1'b1;
                end
                S_MAC: begin
                    for (int c = 0; c < NUM_CH; c++) acc[c] <= acc[c] + ACC_W'(prod[c]);
                    band <= band + CNT_W'(1);
                end
                S_SAT: begin
                    for (int c = 0; c < NUM_CH; c++) data_out[c] <= clamped[c][DATA_W-1 -: OUT_W];
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_eq_band_mixer.sv
// tb/tb_eq_band_mixer.sv - self-checking bench for eq_band_mixer (vector table plus scoreboard)
module tb_eq_band_mixer;

    localparam int NB = 4, NC = 2, DW = 48, GW = 16, OW = 24;

    typedef logic [NB-1:0][DW-1:0]         ch_t;
    typedef logic [NC-1:0][NB-1:0][DW-1:0] din_t;
    typedef logic [NC-1:0][OW-1:0]         dout_t;

    typedef struct {
        logic [NB-1:0][GW-1:0] g;
        logic                  byp;
        din_t                  d;
        dout_t                 e;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, bypass, eq_wr, sample_valid;
    logic [1:0]  eq_wr_sel;
    logic [7:0]  eq_gain_lsb;
    logic [7:0]  eq_gain_msb;
    din_t        data_in;
    dout_t       data_out;
    logic        out_valid, busy, overrun;

    int          checks = 0, failures = 0;
    dout_t       exp_q[$];
    vec_t        vecs[5];
    logic [8:0]  busy_mask, ov_mask;
    int          spurious = 0;

    always #5 clk = ~clk;

    eq_band_mixer dut (
        .clk(clk), .reset(reset), .bypass(bypass), .eq_wr(eq_wr), .eq_wr_sel(eq_wr_sel),
        .eq_gain_lsb(eq_gain_lsb), .eq_gain_msb(eq_gain_msb), .sample_valid(sample_valid),
        .data_in(data_in), .data_out(data_out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                spurious++;
                check("unexpected_out_valid", 64'(data_out), 64'(0));
            end else begin
                dout_t e;
                e = exp_q.pop_front();
                check("data_out_ch0", 64'(data_out[0]), 64'(e[0]));
                check("data_out_ch1", 64'(data_out[1]), 64'(e[1]));
            end
        end
    end

    function automatic ch_t all4(input logic [DW-1:0] x);
        return {x, x, x, x};
    endfunction

    task automatic write_gain(input int b, input logic [GW-1:0] g);
        @(negedge clk);
        eq_wr = 1'b1;
        eq_wr_sel = 2'(b);
        {eq_gain_msb, eq_gain_lsb} = g;
        @(negedge clk);
        eq_wr = 1'b0;
    endtask

    task automatic send_sample(input din_t d, input dout_t e);
        @(negedge clk);
        data_in = d;
        sample_valid = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("result_timeout", 64'(exp_q.size()), 64'(0));
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{g: {4{16'h4000}}, byp: 1'b0,
                    d: {all4(48'h0001_0000_0000), all4(48'h0001_0000_0000)},
                    e: {24'h000400, 24'h000400}};
        vecs[1] = '{g: {16'h0000, 16'h2000, 16'h0000, 16'h0000}, byp: 1'b0,
                    d: {{48'h0, 48'hC000_0000_0000, 48'h0, 48'h0},
                        {48'h0, 48'h4000_0000_0000, 48'h0, 48'h0}},
                    e: {24'hE00000, 24'h200000}};
        vecs[2] = '{g: {4{16'h7FFF}}, byp: 1'b0,
                    d: {all4(48'h8000_0000_0000), all4(48'h7FFF_FFFF_FFFF)},
                    e: {24'h800000, 24'h7FFFFF}};
        vecs[3] = '{g: {16'h0000, 16'h1000, 16'hC000, 16'h4000}, byp: 1'b0,
                    d: {all4(48'hFFFF_FF00_0000),
                        {48'h0500_0000_0000, 48'h0001_0000_0000, 48'h0000_1000_0000, 48'h0000_4000_0000}},
                    e: {24'hFFFFFF, 24'h000070}};
        vecs[4] = '{g: {4{16'h0000}}, byp: 1'b1,
                    d: {{48'hFFFF_FC00_0000, 48'hFFFF_FD00_0000, 48'hFFFF_FE00_0000, 48'hFFFF_FF00_0000},
                        {48'h0000_0400_0000, 48'h0000_0300_0000, 48'h0000_0200_0000, 48'h0000_0100_0000}},
                    e: {24'hFFFFF6, 24'h00000A}};

        reset = 1'b1; bypass = 1'b0; eq_wr = 1'b0; sample_valid = 1'b0;
        eq_wr_sel = '0; eq_gain_lsb = '0; eq_gain_msb = '0; data_in = '0;
        repeat (3) @(negedge clk);
        check("reset_data_out", 64'(data_out), 64'(0));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_overrun", 64'(overrun), 64'(0));
        reset = 1'b0;

        // Default unity gains: latency and busy window
        @(negedge clk);
        data_in = {all4(48'h0001_0000_0000), all4(48'h0001_0000_0000)};
        sample_valid = 1'b1;
        exp_q.push_back({24'h000400, 24'h000400});
        busy_mask = '0; ov_mask = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            busy_mask[k] = busy;
            ov_mask[k]   = out_valid;
        end
        check("busy_window", 64'(busy_mask), 64'(9'h03E));
        check("out_valid_latency", 64'(ov_mask), 64'(9'h040));
        wait_done();

        for (int i = 0; i < 5; i++) begin
            for (int b = 0; b < NB; b++) write_gain(b, vecs[i].g[b]);
            bypass = vecs[i].byp;
            send_sample(vecs[i].d, vecs[i].e);
            wait_done();
            bypass = 1'b0;
        end

        // Gains were left at zero under bypass; they must still be zero
        send_sample({all4(48'h0001_0000_0000), all4(48'h0001_0000_0000)}, '0);
        wait_done();

        // Gain write in the capture cycle applies only from the next sample
        for (int b = 0; b < NB; b++) write_gain(b, 16'h4000);
        @(negedge clk);
        data_in = {all4(48'h0001_0000_0000), all4(48'h0001_0000_0000)};
        sample_valid = 1'b1;
        eq_wr = 1'b1; eq_wr_sel = 2'd1; {eq_gain_msb, eq_gain_lsb} = 16'h0000;
        exp_q.push_back({24'h000400, 24'h000400});
        @(negedge clk);
        sample_valid = 1'b0; eq_wr = 1'b0;
        wait_done();
        send_sample({all4(48'h0001_0000_0000), all4(48'h0001_0000_0000)}, {24'h000300, 24'h000300});
        wait_done();
        check("overrun_clear", 64'(overrun), 64'(0));

        // Second sample_valid two cycles into a computation is dropped
        @(negedge clk);
        data_in = {all4(48'h0001_0000_0000), all4(48'h0001_0000_0000)};
        sample_valid = 1'b1;
        exp_q.push_back({24'h000300, 24'h000300});
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        data_in = '0;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        wait_done();
        repeat (8) @(negedge clk);
        check("overrun_set", 64'(overrun), 64'(1));
        check("data_out_held", 64'(data_out), 64'({24'h000300, 24'h000300}));

        // Reset in the middle of MAC aborts without a result
        @(negedge clk);
        data_in = {all4(48'h0001_0000_0000), all4(48'h0001_0000_0000)};
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_data_out", 64'(data_out), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_overrun", 64'(overrun), 64'(0));
        check("abort_out_valid", 64'(out_valid), 64'(0));
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_result", 64'(spurious), 64'(0));
        check("abort_idle_busy", 64'(busy), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
